riscv_fetch_stage: RTL and testbench

Instruction fetch stage for the RV32I core. Holds the program counter, drives a request/ready handshake to instruction memory, and registers each fetched word into the IF/ID output register. The output register's opcode field feeds the control unit's `opcode` input directly. The stage absorbs decode stalls through a one-entry skid buffer and squashes in-flight fetches on branch/jump redirects.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/riscv_fetch_skid.sv | 34 +++
 rtl/riscv_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_riscv_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, NOP encoding, fetch FSM states, reset PC default.
// FAULT exists only when RV_FETCH_MISALIGN_CHECK_EN is defined.
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,
        FS_HOLD  = 2'd1,
        FS_FLUSH = 2'd2
`ifdef RV_FETCH_MISALIGN_CHECK_EN
        , FS_FAULT = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/riscv_fetch_skid.sv
// One-entry {pc, instr} skid buffer; load writes and sets full, drain or flush empties it.
// Flush has priority over a same-cycle load.
module riscv_fetch_skid
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= 32'h0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// RV32I fetch: PC, imem req/ready handshake, IF/ID register; 1-cycle zero-wait latency, skid absorbs decode stalls.
// Optional misaligned-redirect FAULT state enabled by RV_FETCH_MISALIGN_CHECK_EN.
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode
`ifdef RV_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, flush_addr, flush_addr_n;
    logic [31:0]  rpc;
    logic         id_valid_n;
    logic [31:0]  id_pc_n, id_instr_n;
    logic         hs;
    logic         skid_load, skid_drain, skid_flush, skid_full;
    logic [31:0]  skid_pc, skid_instr;

`ifdef RV_FETCH_MISALIGN_CHECK_EN
    assign rpc              = redirect_pc;
    assign fetch_misaligned = (state == FS_FAULT);
`else
    logic unused_rpc_lo;
    assign rpc           = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lo = ^redirect_pc[1:0];
`endif

    assign id_opcode = id_instr[6:0];

    riscv_fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .flush      (skid_flush),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FS_FETCH;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        flush_addr_n = flush_addr;
        id_valid_n   = id_valid;
        id_pc_n      = id_pc;
        id_instr_n   = id_instr;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_flush   = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = pc;

        case (state)
            FS_FETCH: begin
                imem_req = !rst;
                if (imem_ready && !rst) begin
                    pc_n = pc + 32'd4;
                    if (id_valid && id_stall) begin
                        skid_load = 1'b1;
                        state_n   = FS_HOLD;
                    end else begin
                        id_valid_n = 1'b1;
                        id_pc_n    = pc;
                        id_instr_n = imem_rdata;
                    end
                end else if (!id_stall) begin
                    id_valid_n = 1'b0;
                end
            end
            FS_HOLD: begin
                if (!id_stall && skid_full) begin
                    id_valid_n = 1'b1;
                    id_pc_n    = skid_pc;
                    id_instr_n = skid_instr;
                    skid_drain = 1'b1;
                    state_n    = FS_FETCH;
                end
            end
            FS_FLUSH: begin
                // The old request must finish at its original address; its data is dropped.
                imem_req  = !rst;
                imem_addr = flush_addr;
                if (imem_ready) state_n = FS_FETCH;
                if (!id_stall)  id_valid_n = 1'b0;
            end
            default: begin
                id_valid_n = 1'b0;
            end
        endcase

        hs = imem_req && imem_ready;

        if (redirect_valid) begin
            id_valid_n = 1'b0;
            skid_flush = 1'b1;
            skid_load  = 1'b0;
            skid_drain = 1'b0;
            pc_n       = rpc;
            if (state == FS_FETCH) begin
                flush_addr_n = pc;
                state_n      = hs ? FS_FETCH : FS_FLUSH;
            end else if (state != FS_FLUSH) begin
                state_n = FS_FETCH;
            end
`ifdef RV_FETCH_MISALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) state_n = FS_FAULT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            flush_addr <= RESET_PC;
            id_valid   <= 1'b0;
            id_pc      <= 32'h0;
            id_instr   <= NOP_INSTR;
        end else begin
            pc         <= pc_n;
            flush_addr <= flush_addr_n;
            id_valid   <= id_valid_n;
            id_pc      <= id_pc_n;
            id_instr   <= id_instr_n;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: inputs driven and outputs sampled 1ns after each rising edge.
module tb_riscv_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
`ifdef RV_FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode)
`ifdef RV_FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
        tick(); tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_opcode", id_opcode, 7'b0010011);
`ifdef RV_FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", fetch_misaligned, 0);
`endif

        // Zero-wait streaming from RESET_PC.
        rst = 1'b0; #1;
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 32'h0);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        check("s0_valid", id_valid, 1);
        check("s0_pc", id_pc, 32'h0);
        check("s0_instr", id_instr, 32'h0000_0013);
        check("s0_addr", imem_addr, 32'h4);
        imem_rdata = 32'h0010_0093;
        tick();
        check("s1_pc", id_pc, 32'h4);
        check("s1_instr", id_instr, 32'h0010_0093);
        check("s1_opcode", id_opcode, 7'b0010011);
        check("s1_addr", imem_addr, 32'h8);

        // Stall during the fetch of 8: word goes to skid, no new request.
        id_stall = 1'b1; imem_rdata = 32'hAAAA_0013;
        tick();
        check("st0_req", imem_req, 0);
        check("st0_pc", id_pc, 32'h4);
        check("st0_valid", id_valid, 1);
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        check("st1_req", imem_req, 0);
        check("st1_instr", id_instr, 32'h0010_0093);
        tick();
        check("st2_req", imem_req, 0);
        check("st2_pc", id_pc, 32'h4);
        id_stall = 1'b0;
        tick();
        check("rel_pc", id_pc, 32'h8);
        check("rel_instr", id_instr, 32'hAAAA_0013);
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 32'hC);
        imem_rdata = 32'h00C0_0113;
        tick();
        check("w12_pc", id_pc, 32'hC);
        check("w12_instr", id_instr, 32'h00C0_0113);
        check("w12_addr", imem_addr, 32'h10);

        // Redirect while waiting on a slow response: FLUSH.
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("fl0_addr", imem_addr, 32'h10);
        check("fl0_req", imem_req, 1);
        check("fl0_valid", id_valid, 0);
        tick();
        check("fl1_addr", imem_addr, 32'h10);
        check("fl1_valid", id_valid, 0);
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("fl2_addr", imem_addr, 32'h100);
        check("fl2_valid", id_valid, 0);
        check("fl2_instr", id_instr, 32'h00C0_0113);

        // Redirect coinciding with handshake and stall.
        imem_rdata = 32'h0010_0113;
        tick();
        check("r100_pc", id_pc, 32'h100);
        check("r100_valid", id_valid, 1);
        id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        imem_rdata = 32'hDEAD_0013;
        tick();
        redirect_valid = 1'b0;
        check("rs_valid", id_valid, 0);
        check("rs_req", imem_req, 1);
        check("rs_addr", imem_addr, 32'h40);
        id_stall = 1'b0; imem_rdata = 32'h0000_0067;
        tick();
        check("r40_pc", id_pc, 32'h40);
        check("r40_instr", id_instr, 32'h0000_0067);
        check("r40_addr", imem_addr, 32'h44);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wr0_addr", imem_addr, 32'hFFFF_FFFC);
        check("wr0_valid", id_valid, 0);
        imem_rdata = 32'h0000_0013;
        tick();
        check("wr1_pc", id_pc, 32'hFFFF_FFFC);
        check("wr1_addr", imem_addr, 32'h0);
        tick();
        check("wr2_addr", imem_addr, 32'h4);

        // Reset while a request is outstanding.
        imem_ready = 1'b0;
        tick();
        check("mw_addr", imem_addr, 32'h4);
        rst = 1'b1; #1;
        check("mr_req_now", imem_req, 0);
        tick();
        check("mr_req", imem_req, 0);
        check("mr_valid", id_valid, 0);
        rst = 1'b0; #1;
        check("mr_restart_req", imem_req, 1);
        check("mr_restart_addr", imem_addr, 32'h0);

`ifdef RV_FETCH_MISALIGN_CHECK_EN
        imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("mis_flag", fetch_misaligned, 1);
        check("mis_req", imem_req, 0);
        check("mis_valid", id_valid, 0);
        tick();
        check("mis_sticky", fetch_misaligned, 1);
        check("mis_req2", imem_req, 0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("mis_clear", fetch_misaligned, 0);
        check("mis_req3", imem_req, 1);
        check("mis_addr", imem_addr, 32'h200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
